pll_clk_mon: RTL and testbench

- Checks the PLL output frequency against the crystal clock that feeds the PLL.
- Samples a divided copy of the PLL output (e.g. CLKOUTD), counts its rising edges over a fixed gate window of `clkin` cycles, and reports the count.
- Flags whether each window's count is within tolerance and derives a debounced `locked` status.
- Sits beside the PLL wrapper in the composite-video top level; gates the video pipeline enable and drives a status LED.

---
 rtl/pll_clk_mon.sv | 84 ++++++++
 tb/tb_pll_clk_mon.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pll_clk_mon.sv
// pll_clk_mon: measures a divided PLL clock against clkin over fixed gate windows and derives lock status
// Optional sticky loss-of-lock flag enabled by defining PLL_CLK_MON_STICKY_LOST_EN.
module pll_clk_mon #(
  parameter int GATE_CYCLES = 27000,
  parameter int COUNT_W     = 16,
  parameter int EXP_COUNT   = 6750,
  parameter int TOL         = 8,
  parameter int LOCK_N      = 3
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               clr,
  output logic [COUNT_W-1:0] count_o,
  output logic               valid,
  output logic               in_range,
  output logic               locked,
  output logic               lost
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam int LO = EXP_COUNT - TOL;
  localparam int HI = EXP_COUNT + TOL;
  typedef enum logic {WARM, MEAS} state_t;
  state_t state, state_n;
  logic sync1, sync2, prev;
  logic [GW-1:0] gate;
  logic [COUNT_W-1:0] cnt, cnt_fin;
  logic [3:0] run, run_n;
  logic rise, close, upd, win_ok, drop;
  assign rise  = sync2 & ~prev;
  assign close = gate == '0;
  // next state, closing-window count (edge in closing cycle included) and lock debounce
  always_comb begin
    state_n = close ? MEAS : state;
    upd     = close && state == MEAS;
    cnt_fin = (cnt == CNT_MAX) ? cnt : cnt + COUNT_W'(rise);
    win_ok  = (int'({1'b0, cnt_fin}) >= LO) && (int'({1'b0, cnt_fin}) <= HI);
    run_n   = !win_ok ? 4'd0 : (run == 4'(LOCK_N)) ? run : run + 4'd1;
    drop    = upd && locked && !win_ok;
  end
  // synchronizer, gate and edge counters, FSM state and published results
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      gate     <= GATE_LOAD;
      cnt      <= '0;
      state    <= WARM;
      valid    <= 1'b0;
      count_o  <= '0;
      in_range <= 1'b0;
      locked   <= 1'b0;
      run      <= 4'd0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
      gate  <= close ? GATE_LOAD : gate - 1'b1;
      cnt   <= close ? '0 : cnt_fin;
      state <= state_n;
      valid <= upd;
      if (upd) begin
        count_o  <= cnt_fin;
        in_range <= win_ok;
        run      <= run_n;
        locked   <= run_n == 4'(LOCK_N);
      end
    end
  end
`ifdef PLL_CLK_MON_STICKY_LOST_EN
  // sticky loss flag: a lock drop sets it and beats a simultaneous clear
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) lost <= 1'b0;
    else lost <= drop ? 1'b1 : clr ? 1'b0 : lost;
  end
`else
  logic unused_sticky;
  assign unused_sticky = clr ^ drop;
  assign lost = 1'b0;
`endif
endmodule

// File: tb/tb_pll_clk_mon.sv
// tb_pll_clk_mon: directed bench for pll_clk_mon (gate 100, expect 25 +/- 1, lock after 3)
module tb_pll_clk_mon;
`ifdef PLL_CLK_MON_STICKY_LOST_EN
  localparam int STICKY = 1;
`else
  localparam int STICKY = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, sig_in = 1'b0, clr = 1'b0;
  logic [15:0] count_o;
  logic valid, in_range, locked, lost;
  logic [3:0] s_count;
  logic s_valid, s_in_range, s_locked, s_lost;
  int cyc = 0, per = 4, ph = 0, checks = 0, fails = 0;
  bit auto_gen = 1'b1;
  pll_clk_mon #(.GATE_CYCLES(100), .COUNT_W(16), .EXP_COUNT(25), .TOL(1), .LOCK_N(3)) dut (
    .clkin(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr), .count_o(count_o),
    .valid(valid), .in_range(in_range), .locked(locked), .lost(lost));
  pll_clk_mon #(.GATE_CYCLES(100), .COUNT_W(4), .EXP_COUNT(25), .TOL(1), .LOCK_N(3)) u_sat (
    .clkin(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr), .count_o(s_count),
    .valid(s_valid), .in_range(s_in_range), .locked(s_locked), .lost(s_lost));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (auto_gen) begin
      ph = (ph + 1 >= per) ? 0 : ph + 1;
      sig_in = ph < per / 2;
    end
  endtask
  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic wait_valid(input string tag, input int exp);
    int lim;
    lim = cyc + 250;
    step();
    while (!valid && cyc < lim) step();
    chk(tag, cyc, exp);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, int'(count_o), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_in_range"}, int'(in_range), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_lost"}, int'(lost), 0);
    chk({tag, "_sat_count"}, int'(s_count), 0);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
    wait_valid("first_valid_cycle", 200);
    chk("first_count", int'(count_o), 25);
    chk("first_in_range", int'(in_range), 1);
    chk("first_locked", int'(locked), 0);
    chk("first_lost", int'(lost), 0);
    chk("sat_count", int'(s_count), 15);
    chk("sat_in_range", int'(s_in_range), 0);
    chk("sat_valid", int'(s_valid), 1);
    step();
    chk("valid_one_cycle", int'(valid), 0);
    chk("count_hold", int'(count_o), 25);
    wait_valid("second_valid_cycle", 300);
    chk("second_locked", int'(locked), 0);
    wait_valid("third_valid_cycle", 400);
    chk("third_in_range", int'(in_range), 1);
    chk("third_locked", int'(locked), 1);
    chk("sat_locked", int'(s_locked), 0);
    run_to(489);
    per = 5;
    ph = 4;
    wait_valid("mixed_valid_cycle", 500);
    chk("mixed_in_range", int'(in_range), 1);
    chk("mixed_locked", int'(locked), 1);
    wait_valid("slow_valid_cycle", 600);
    chk("slow_count", int'(count_o), 20);
    chk("slow_in_range", int'(in_range), 0);
    chk("slow_locked_drop", int'(locked), 0);
    chk("slow_lost", int'(lost), STICKY);
    chk("slow_sat_count", int'(s_count), 15);
    run_to(605);
    chk("lost_hold", int'(lost), STICKY);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("lost_cleared", int'(lost), 0);
    run_to(689);
    per = 4;
    ph = 3;
    wait_valid("relock1_cycle", 700);
    chk("relock1_in_range", int'(in_range), 0);
    wait_valid("relock2_cycle", 800);
    chk("relock2_in_range", int'(in_range), 1);
    wait_valid("relock3_cycle", 900);
    chk("relock3_locked", int'(locked), 0);
    wait_valid("relock4_cycle", 1000);
    chk("relock4_locked", int'(locked), 1);
    run_to(1089);
    per = 5;
    ph = 4;
    wait_valid("pre_drop_cycle", 1100);
    chk("pre_drop_locked", int'(locked), 1);
    run_to(1199);
    clr = 1'b1;
    wait_valid("drop_clr_cycle", 1200);
    clr = 1'b0;
    chk("drop_clr_locked", int'(locked), 0);
    chk("drop_clr_set_wins", int'(lost), STICKY);
    step();
    chk("drop_clr_after", int'(lost), STICKY);
    run_to(1250);
    rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    repeat (2) step();
    auto_gen = 1'b0;
    sig_in = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    wait_valid("rst_first_valid_cycle", 200);
    chk("quiet_count", int'(count_o), 0);
    run_to(297);
    sig_in = 1'b1;
    wait_valid("edge_close_cycle", 300);
    chk("edge_in_closing_window", int'(count_o), 1);
    run_to(350);
    sig_in = 1'b0;
    wait_valid("edge_next_cycle", 400);
    chk("edge_next_window", int'(count_o), 0);
    run_to(498);
    sig_in = 1'b1;
    wait_valid("late_edge_cycle", 500);
    chk("late_edge_excluded", int'(count_o), 0);
    run_to(550);
    sig_in = 1'b0;
    wait_valid("late_edge_next_cycle", 600);
    chk("late_edge_next_window", int'(count_o), 1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
